// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_pkg                                                     |
// | Description : Shared UART types and constants for the transmit and         |
// |               receive ends of the link.                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_t;

   localparam int   UART_DATA_W    = 8;
   localparam logic UART_START_BIT = 1'b0;
   localparam logic UART_STOP_BIT  = 1'b1;

   function automatic logic uart_parity(input logic [UART_DATA_W-1:0] byte_val,
                                        input logic                   odd);
      return (^byte_val) ^ odd;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_baud_cnt                                                |
// | Description : Per-bit clock counter; flags the last and second-to-last     |
// |               clock of every serial bit.                                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_baud_cnt #(
   parameter int CLKS_PER_BIT = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic bit_end,
   output logic bit_pre_end
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign bit_end     = (cnt_q == CNT_LAST);
   assign bit_pre_end = (cnt_q == CNT_PRE);

   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (clr || bit_end) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_piso.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_piso                                                    |
// | Description : UART transmitter, 8-bit byte out LSB-first with start bit,   |
// |               optional parity bit (macro UART_PISO_PARITY_EN) and stop bit.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_piso
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 8,
   parameter int PARITY_ODD   = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [UART_DATA_W-1:0] data_in,
   input  logic                   send,
   output logic                   data_tx,
   output logic                   busy,
   output logic                   tx_done
);

   uart_state_t            state_q, state_d;
   logic [UART_DATA_W-1:0] shift_q, shift_d;
   logic [2:0]             bit_cnt_q, bit_cnt_d;
   logic                   data_tx_q, data_tx_d;
   logic                   busy_q, busy_d;
   logic                   tx_done_q, tx_done_d;
   logic                   accept;
   logic                   cnt_clr;
   logic                   bit_end;
   logic                   bit_pre_end;

`ifdef UART_PISO_PARITY_EN
   logic parity_q, parity_d;
`else
   logic unused_cfg;
   assign unused_cfg = (PARITY_ODD != 0);
`endif

   // busy_q is low only in IDLE and the final stop clock, so accept can only fire there.
   assign accept  = send & ~busy_q;
   assign cnt_clr = (state_q == IDLE);

   uart_baud_cnt #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud_cnt (
      .clk         (clk),
      .rst         (rst),
      .clr         (cnt_clr),
      .bit_end     (bit_end),
      .bit_pre_end (bit_pre_end)
   );

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      data_tx_d = data_tx_q;
      busy_d    = busy_q;
      tx_done_d = 1'b0;
`ifdef UART_PISO_PARITY_EN
      parity_d  = parity_q;
`endif

      case (state_q)
         IDLE: begin
            data_tx_d = UART_STOP_BIT;
            busy_d    = 1'b0;
         end
         START: begin
            if (bit_end) begin
               state_d   = DATA;
               data_tx_d = shift_q[0];
               shift_d   = shift_q >> 1;
               bit_cnt_d = 3'd0;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_cnt_q == 3'd7) begin
                  bit_cnt_d = 3'd0;
`ifdef UART_PISO_PARITY_EN
                  state_d   = PARITY;
                  data_tx_d = parity_q;
`else
                  state_d   = STOP;
                  data_tx_d = UART_STOP_BIT;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  data_tx_d = shift_q[0];
                  shift_d   = shift_q >> 1;
               end
            end
         end
         PARITY: begin
`ifdef UART_PISO_PARITY_EN
            if (bit_end) begin
               state_d   = STOP;
               data_tx_d = UART_STOP_BIT;
            end
`else
            state_d   = IDLE;
            data_tx_d = UART_STOP_BIT;
            busy_d    = 1'b0;
`endif
         end
         STOP: begin
            // Registered outputs look one clock ahead into the final stop clock.
            if (bit_pre_end) begin
               busy_d    = 1'b0;
               tx_done_d = 1'b1;
            end
            if (bit_end) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d   = IDLE;
            data_tx_d = UART_STOP_BIT;
            busy_d    = 1'b0;
         end
      endcase

      if (accept) begin
         state_d   = START;
         shift_d   = data_in;
         bit_cnt_d = 3'd0;
         data_tx_d = UART_START_BIT;
         busy_d    = 1'b1;
`ifdef UART_PISO_PARITY_EN
         parity_d  = uart_parity(data_in, (PARITY_ODD != 0));
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bit_cnt_q <= 3'd0;
         data_tx_q <= UART_STOP_BIT;
         busy_q    <= 1'b0;
         tx_done_q <= 1'b0;
`ifdef UART_PISO_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         data_tx_q <= data_tx_d;
         busy_q    <= busy_d;
         tx_done_q <= tx_done_d;
`ifdef UART_PISO_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

   assign data_tx = data_tx_q;
   assign busy    = busy_q;
   assign tx_done = tx_done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_piso.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_piso                                                 |
// | Description : Self-checking bench for uart_piso (even and odd parity       |
// |               instances side by side) against a frame-level model.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_uart_piso;

   localparam int C = 4;
`ifdef UART_PISO_PARITY_EN
   localparam int NBITS   = 11;
   localparam bit HAS_PAR = 1'b1;
`else
   localparam int NBITS   = 10;
   localparam bit HAS_PAR = 1'b0;
`endif
   localparam int FRAME = NBITS * C;

   logic       clk = 1'b0;
   logic       rst;
   logic       send;
   logic [7:0] data_in;
   logic       tx_e, busy_e, done_e;
   logic       tx_o, busy_o, done_o;

   int         n_cmp = 0;
   int         n_err = 0;
   int         pos;        // 0 = idle, else 1..FRAME = clock index within the frame
   logic [7:0] cur;
   string      phase;

   always #5 clk = ~clk;

   uart_piso #(.CLKS_PER_BIT(C), .PARITY_ODD(0)) u_even (
      .clk     (clk),
      .rst     (rst),
      .data_in (data_in),
      .send    (send),
      .data_tx (tx_e),
      .busy    (busy_e),
      .tx_done (done_e)
   );

   uart_piso #(.CLKS_PER_BIT(C), .PARITY_ODD(1)) u_odd (
      .clk     (clk),
      .rst     (rst),
      .data_in (data_in),
      .send    (send),
      .data_tx (tx_o),
      .busy    (busy_o),
      .tx_done (done_o)
   );

   // Frame order: start 0, d0..d7, [parity], stop 1.
   function automatic logic frame_bit(input logic [7:0] b, input int idx, input bit odd);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return b[idx-1];
      if (HAS_PAR && idx == 9) return (^b) ^ odd;
      return 1'b1;
   endfunction

   task automatic check(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s/%s at %0t: observed %b expected %b", phase, tag, $time, obs, exp);
      end
   endtask

   task automatic cycle(input logic r, input logic s, input logic [7:0] d);
      logic exp_busy_now;
      logic exp_te, exp_to, exp_b, exp_d;
      rst     = r;
      send    = s;
      data_in = d;
      exp_busy_now = (pos != 0) && (pos != FRAME);
      @(posedge clk);
      if (r) begin
         pos = 0;
      end else begin
         if (pos != 0) pos = (pos == FRAME) ? 0 : pos + 1;
         if (s && !exp_busy_now) begin
            pos = 1;
            cur = d;
         end
      end
      #1;
      exp_te = (pos == 0) ? 1'b1 : frame_bit(cur, (pos - 1) / C, 1'b0);
      exp_to = (pos == 0) ? 1'b1 : frame_bit(cur, (pos - 1) / C, 1'b1);
      exp_b  = (pos != 0) && (pos != FRAME);
      exp_d  = (pos == FRAME);
      check("tx_even",   tx_e,   exp_te);
      check("busy_even", busy_e, exp_b);
      check("done_even", done_e, exp_d);
      check("tx_odd",    tx_o,   exp_to);
      check("busy_odd",  busy_o, exp_b);
      check("done_odd",  done_o, exp_d);
   endtask

   initial begin
      pos     = 0;
      cur     = 8'h00;
      rst     = 1'b1;
      send    = 1'b0;
      data_in = 8'h00;

      phase = "reset";
      repeat (5) cycle(1'b1, 1'b0, 8'h00);
      phase = "idle";
      repeat (20) cycle(1'b0, 1'b0, 8'($urandom));

      phase = "frame_a5";
      cycle(1'b0, 1'b1, 8'hA5);
      repeat (FRAME + 5) cycle(1'b0, 1'b0, 8'($urandom));

      phase = "frame_01";
      cycle(1'b0, 1'b1, 8'h01);
      repeat (FRAME + 5) cycle(1'b0, 1'b0, 8'($urandom));

      phase = "back_to_back";
      cycle(1'b0, 1'b1, 8'h00);
      repeat (FRAME) cycle(1'b0, 1'b1, 8'hFF);
      repeat (FRAME + 5) cycle(1'b0, 1'b0, 8'($urandom));

      phase = "ignored_req_reset";
      cycle(1'b0, 1'b1, 8'h81);
      repeat (10) cycle(1'b0, 1'b0, 8'($urandom));
      repeat (5) cycle(1'b0, 1'b1, 8'h3C);
      repeat (4) cycle(1'b0, 1'b0, 8'($urandom));
      cycle(1'b1, 1'b0, 8'h00);
      repeat (3) cycle(1'b0, 1'b0, 8'($urandom));
      cycle(1'b0, 1'b1, 8'h5A);
      repeat (FRAME + 5) cycle(1'b0, 1'b0, 8'($urandom));

      phase = "random";
      for (int i = 0; i < 600; i++) begin
         cycle(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) == 0), 8'($urandom));
      end
      repeat (FRAME + 5) cycle(1'b0, 1'b0, 8'($urandom));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
